// File: rtl/dvi_frame_reader.sv
//----------------------------------------------------------------------------
// Module      : dvi_frame_reader
// Description : DVI raster timing generator and frame-buffer read-FIFO consumer.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dvi_frame_reader #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int START_LEVEL    = 256,
    parameter int NEWFRAME_WIDTH = 4
) (
    input  logic        dvi_clk,
    input  logic        reset_n,
    input  logic [31:0] iData,
    input  logic [8:0]  fifo_rdusedw,
    input  logic        fifo_underflow,
    output logic        read_init,
    output logic        read_rstn,
    output logic        rd_new_frame,
    output logic        oHS,
    output logic        oVS,
    output logic        oDE,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        underflow_sticky,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int NFW     = $clog2(NEWFRAME_WIDTH + 1);

    localparam logic [HW-1:0]  c_H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  c_H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  c_H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  c_H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  c_V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  c_V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  c_V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  c_V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0]     c_START_LEVEL  = 9'(START_LEVEL);
    localparam logic [NFW-1:0] c_NF_LOAD      = NFW'(NEWFRAME_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_FILL  = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic            w_act;
    logic            w_de;
    logic            w_hs_n;
    logic            w_vs_n;
    logic            w_frame_end;
    logic            w_nf_start;
    logic [2:0]      r_de_pipe;
    logic [2:0]      r_hs_pipe;
    logic [2:0]      r_vs_pipe;
    logic            r_read_init;
    logic            r_de;
    logic            r_hs;
    logic            r_vs;
    logic [7:0]      r_r;
    logic [7:0]      r_g;
    logic [7:0]      r_b;
    logic            r_nf;
    logic [NFW-1:0]  r_nf_cnt;
    logic            r_uf_sticky;
    logic [15:0]     r_uf_cnt;
    logic            w_unused;

    // The top byte of the buffer word carries no pixel information.
    assign w_unused = &{1'b0, iData[31:24]};

    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign w_act       = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_de        = w_act && (r_state == RUN);
    assign w_hs_n      = !((r_h_cnt >= c_H_SYNC_START) && (r_h_cnt < c_H_SYNC_END));
    assign w_vs_n      = !((r_v_cnt >= c_V_SYNC_START) && (r_v_cnt < c_V_SYNC_END));
    assign w_frame_end = (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);
    assign w_nf_start  = (r_h_cnt == '0) && (r_v_cnt == c_V_SYNC_START);

    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_state <= WAIT_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Once the fill level has been seen, a later drain does not send us back.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FILL:  if (fifo_rdusedw >= c_START_LEVEL) w_state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (w_frame_end) w_state_nxt = RUN;
            RUN:        w_state_nxt = RUN;
            default:    w_state_nxt = WAIT_FILL;
        endcase
    end

    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_read_init <= 1'b0;
        end else begin
            r_read_init <= (w_state_nxt == RUN);
        end
    end

    // Stage 0 of the DE pipe is the fetch strobe; the buffer returns data two stages later.
    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
            r_de      <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else begin
            r_de_pipe <= {r_de_pipe[1:0], w_de};
            r_hs_pipe <= {r_hs_pipe[1:0], w_hs_n};
            r_vs_pipe <= {r_vs_pipe[1:0], w_vs_n};
            r_de      <= r_de_pipe[2];
            r_hs      <= r_hs_pipe[2];
            r_vs      <= r_vs_pipe[2];
            if (r_de_pipe[2]) begin
                r_r <= iData[23:16];
                r_g <= iData[15:8];
                r_b <= iData[7:0];
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    // Frame pulse runs in every state so the buffer realigns before display starts.
    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_nf     <= 1'b0;
            r_nf_cnt <= '0;
        end else if (w_nf_start) begin
            r_nf     <= 1'b1;
            r_nf_cnt <= c_NF_LOAD;
        end else if (r_nf_cnt != '0) begin
            r_nf_cnt <= r_nf_cnt - NFW'(1);
        end else begin
            r_nf     <= 1'b0;
        end
    end

    always_ff @(posedge dvi_clk) begin
        if (!reset_n) begin
            r_uf_sticky <= 1'b0;
            r_uf_cnt    <= '0;
        end else if ((r_state == RUN) && fifo_underflow) begin
            r_uf_sticky <= 1'b1;
            if (r_uf_cnt != 16'hFFFF) begin
                r_uf_cnt <= r_uf_cnt + 16'd1;
            end
        end
    end

    assign read_init        = r_read_init;
    assign read_rstn        = r_de_pipe[0];
    assign rd_new_frame     = r_nf;
    assign oHS              = r_hs;
    assign oVS              = r_vs;
    assign oDE              = r_de;
    assign oR               = r_r;
    assign oG               = r_g;
    assign oB               = r_b;
    assign underflow_sticky = r_uf_sticky;
    assign underflow_cnt    = r_uf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dvi_frame_reader.sv
//----------------------------------------------------------------------------
// Module      : tb_dvi_frame_reader
// Description : Directed cycle-table bench for dvi_frame_reader (14x7 raster).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_dvi_frame_reader;

    localparam int LAST_CYC = 445;
    localparam int S_INIT = 0, S_RSTN = 1, S_DE = 2, S_HS = 3, S_VS = 4;
    localparam int S_NF = 5, S_RGB = 6, S_STICKY = 7, S_CNT = 8;

    logic        dvi_clk = 1'b0;
    logic        reset_n;
    logic [31:0] iData;
    logic [8:0]  fifo_rdusedw;
    logic        fifo_underflow;
    logic        read_init, read_rstn, rd_new_frame;
    logic        oHS, oVS, oDE;
    logic [7:0]  oR, oG, oB;
    logic        underflow_sticky;
    logic [15:0] underflow_cnt;

    always #5 dvi_clk = ~dvi_clk;

    dvi_frame_reader #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .START_LEVEL(4), .NEWFRAME_WIDTH(4)
    ) dut (
        .dvi_clk          (dvi_clk),
        .reset_n          (reset_n),
        .iData            (iData),
        .fifo_rdusedw     (fifo_rdusedw),
        .fifo_underflow   (fifo_underflow),
        .read_init        (read_init),
        .read_rstn        (read_rstn),
        .rd_new_frame     (rd_new_frame),
        .oHS              (oHS),
        .oVS              (oVS),
        .oDE              (oDE),
        .oR               (oR),
        .oG               (oG),
        .oB               (oB),
        .underflow_sticky (underflow_sticky),
        .underflow_cnt    (underflow_cnt)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [23:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        int          cyc;
        logic        rst_n;
        logic [8:0]  used;
        logic        ufl;
    } stim_t;

    chk_t  chks[$];
    stim_t stims[$];
    int    errors = 0;
    int    checks = 0;

    task automatic expect_at(input int c, input int s, input logic [23:0] v, input string n);
        chk_t e;
        e.cyc = c; e.sel = s; e.exp = v; e.name = n;
        chks.push_back(e);
    endtask

    task automatic stim_at(input int c, input logic r, input logic [8:0] u, input logic f);
        stim_t e;
        e.cyc = c; e.rst_n = r; e.used = u; e.ufl = f;
        stims.push_back(e);
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] sig_val(input int s);
        case (s)
            S_INIT:   return {23'd0, read_init};
            S_RSTN:   return {23'd0, read_rstn};
            S_DE:     return {23'd0, oDE};
            S_HS:     return {23'd0, oHS};
            S_VS:     return {23'd0, oVS};
            S_NF:     return {23'd0, rd_new_frame};
            S_RGB:    return {oR, oG, oB};
            S_STICKY: return {23'd0, underflow_sticky};
            default:  return {8'd0, underflow_cnt};
        endcase
    endfunction

    // Each cycle's word is distinct so any misalignment shows up in RGB.
    function automatic logic [31:0] word(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8'hAA, 8'h11 ^ b, 8'h22 ^ b, 8'h33 ^ b};
    endfunction

    logic       cur_rst;
    logic [8:0] cur_used;
    logic       cur_ufl;
    int         de_frame, de_line, hs_line, vs_frame, nf_frame, first_hs;

    initial begin
        reset_n = 1'b0; iData = '0; fifo_rdusedw = '0; fifo_underflow = 1'b0;
        cur_rst = 1'b1; cur_used = '0; cur_ufl = 1'b0;
        de_frame = 0; de_line = 0; hs_line = 0; vs_frame = 0; nf_frame = 0; first_hs = -1;

        stim_at(0,   1'b1, 9'd0, 1'b0);
        stim_at(5,   1'b1, 9'd0, 1'b1);
        stim_at(8,   1'b1, 9'd0, 1'b0);
        stim_at(10,  1'b1, 9'd4, 1'b0);
        stim_at(30,  1'b1, 9'd0, 1'b0);
        stim_at(200, 1'b1, 9'd0, 1'b1);
        stim_at(203, 1'b1, 9'd0, 1'b0);
        stim_at(240, 1'b0, 9'd0, 1'b0);
        stim_at(241, 1'b1, 9'd0, 1'b0);
        stim_at(338, 1'b1, 9'd4, 1'b0);
        stim_at(339, 1'b1, 9'd0, 1'b0);

        expect_at(0, S_INIT, 0, "rst_init");     expect_at(0, S_RSTN, 0, "rst_rstn");
        expect_at(0, S_DE, 0, "rst_de");         expect_at(0, S_HS, 1, "rst_hs");
        expect_at(0, S_VS, 1, "rst_vs");         expect_at(0, S_NF, 0, "rst_nf");
        expect_at(0, S_RGB, 0, "rst_rgb");       expect_at(0, S_STICKY, 0, "rst_sticky");
        expect_at(0, S_CNT, 0, "rst_cnt");
        expect_at(9, S_CNT, 0, "ufl_wait_cnt");  expect_at(9, S_STICKY, 0, "ufl_wait_sticky");
        expect_at(13, S_HS, 1, "hs_pre");        expect_at(14, S_HS, 0, "hs_lo0");
        expect_at(15, S_HS, 0, "hs_lo1");        expect_at(16, S_HS, 1, "hs_post");
        expect_at(70, S_NF, 0, "nf_pre");        expect_at(71, S_NF, 1, "nf_first");
        expect_at(74, S_NF, 1, "nf_last");       expect_at(75, S_NF, 0, "nf_post");
        expect_at(73, S_VS, 1, "vs_pre");        expect_at(74, S_VS, 0, "vs_first");
        expect_at(87, S_VS, 0, "vs_last");       expect_at(88, S_VS, 1, "vs_post");
        expect_at(97, S_INIT, 0, "init_pre");    expect_at(98, S_INIT, 1, "init_rise");
        expect_at(98, S_RSTN, 0, "rstn_pre");    expect_at(99, S_RSTN, 1, "rstn_first");
        expect_at(101, S_DE, 0, "de_pre");       expect_at(102, S_DE, 1, "de_first");
        expect_at(102, S_RGB, 24'h744756, "rgb_px0");
        expect_at(105, S_RGB, 24'h794A5B, "rgb_px3");
        expect_at(106, S_RSTN, 1, "rstn_px7");   expect_at(107, S_RSTN, 0, "rstn_blank");
        expect_at(109, S_DE, 1, "de_px7");       expect_at(109, S_RGB, 24'h7D4E5F, "rgb_px7");
        expect_at(110, S_DE, 0, "de_blank");     expect_at(110, S_RGB, 0, "rgb_blank");
        expect_at(112, S_HS, 0, "hs_run");       expect_at(114, S_HS, 1, "hs_run_post");
        expect_at(113, S_RSTN, 1, "rstn_line1"); expect_at(116, S_DE, 1, "de_line1");
        expect_at(151, S_DE, 1, "de_lastpx");    expect_at(153, S_DE, 0, "de_last_blank");
        expect_at(158, S_DE, 0, "de_vfp");
        expect_at(168, S_NF, 0, "nf2_pre");      expect_at(169, S_NF, 1, "nf2_first");
        expect_at(172, S_NF, 1, "nf2_last");     expect_at(173, S_NF, 0, "nf2_post");
        expect_at(200, S_CNT, 0, "ufl_cnt0");    expect_at(201, S_CNT, 1, "ufl_cnt1");
        expect_at(201, S_STICKY, 1, "ufl_sticky");
        expect_at(201, S_DE, 1, "ufl_de");       expect_at(201, S_RGB, 0, "ufl_rgb");
        expect_at(202, S_CNT, 2, "ufl_cnt2");    expect_at(203, S_CNT, 3, "ufl_cnt3");
        expect_at(204, S_DE, 1, "post_ufl_de");  expect_at(204, S_RGB, 24'hDAE9F8, "post_ufl_rgb");
        expect_at(230, S_CNT, 3, "ufl_hold");    expect_at(230, S_STICKY, 1, "sticky_hold");
        expect_at(240, S_INIT, 1, "init_held");
        expect_at(241, S_DE, 0, "mrst_de");      expect_at(241, S_INIT, 0, "mrst_init");
        expect_at(241, S_RSTN, 0, "mrst_rstn");  expect_at(241, S_CNT, 0, "mrst_cnt");
        expect_at(241, S_STICKY, 0, "mrst_sticky");
        expect_at(241, S_HS, 1, "mrst_hs");      expect_at(241, S_RGB, 0, "mrst_rgb");
        expect_at(242, S_DE, 0, "flush_de0");    expect_at(243, S_DE, 0, "flush_de1");
        expect_at(244, S_DE, 0, "flush_de2");
        expect_at(252, S_HS, 1, "mrst_hs_realign"); expect_at(255, S_HS, 0, "mrst_hs_lo");
        expect_at(311, S_NF, 0, "mrst_nf_pre");  expect_at(312, S_NF, 1, "mrst_nf");
        expect_at(338, S_INIT, 0, "sim_init_a"); expect_at(339, S_INIT, 0, "sim_no_skip");
        expect_at(340, S_RSTN, 0, "sim_rstn");   expect_at(343, S_DE, 0, "sim_de");
        expect_at(436, S_INIT, 0, "sim_init_b"); expect_at(437, S_INIT, 1, "sim_run");
        expect_at(438, S_RSTN, 1, "sim_rstn_on"); expect_at(441, S_DE, 1, "sim_de_on");

        repeat (3) @(posedge dvi_clk);
        for (int k = 0; k <= LAST_CYC; k++) begin
            @(negedge dvi_clk);
            foreach (chks[i]) begin
                if (chks[i].cyc == k) begin
                    check($sformatf("%s@%0d", chks[i].name, k), sig_val(chks[i].sel), chks[i].exp);
                end
            end

            if (k >= 100 && k < 198 && oDE) de_frame++;
            if (k >= 100 && k < 114 && oDE) de_line++;
            if (k >= 112 && k < 126 && !oHS) hs_line++;
            if (k >= 102 && first_hs < 0 && !oHS) first_hs = k;
            if (k >= 98 && k < 196) begin
                if (!oVS) vs_frame++;
                if (rd_new_frame) nf_frame++;
            end
            if (k == 114) check("de_per_line", 24'(de_line), 24'd8);
            if (k == 126) check("hs_width", 24'(hs_line), 24'd2);
            if (k == 126) check("hs_after_de", 24'(first_hs), 24'd112);
            if (k == 196) check("vs_width", 24'(vs_frame), 24'd14);
            if (k == 196) check("nf_width", 24'(nf_frame), 24'd4);
            if (k == 198) check("de_per_frame", 24'(de_frame), 24'd32);

            foreach (stims[i]) begin
                if (stims[i].cyc == k) begin
                    cur_rst  = stims[i].rst_n;
                    cur_used = stims[i].used;
                    cur_ufl  = stims[i].ufl;
                end
            end
            reset_n        = cur_rst;
            fifo_rdusedw   = cur_used;
            fifo_underflow = cur_ufl;
            iData          = cur_ufl ? 32'd0 : word(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
